video_timing_gen: RTL and testbench

Parametrised single-channel display timing generator and pixel pipeline; one instance per screen (VGA, LCD) replaces the fixed-resolution screen driver. Generates h/v counters, sync and data-enable, issues linear read addresses to the framebuffer read port, maps 4-bit colour indices through a writable 16-entry palette to RGB, and re-aligns sync and enable with the delayed pixel data. The optional genlock input lets the LCD instance slave its frame start to the global vsync.

---
 rtl/video_timing_gen_if.sv | 33 +++
 rtl/video_timing_gen.sv | 143 ++++++++++++++
 tb/tb_video_timing_gen.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// Screen-side bundle: framebuffer read port, palette write port, genlock request and pin-aligned video outputs.
// master = timing generator, slave = framebuffer/palette host and display pins.
interface video_timing_gen_if #(
    parameter int ADDR_W = 19,
    parameter int R_W    = 5,
    parameter int G_W    = 5,
    parameter int B_W    = 5
);
    logic                     fb_rd_en;
    logic [ADDR_W-1:0]        fb_addr;
    logic [3:0]               fb_data;
    logic                     pal_we;
    logic [3:0]               pal_idx;
    logic [R_W+G_W+B_W-1:0]   pal_rgb;
    logic                     frame_sync_in;
    logic                     hsync;
    logic                     vsync;
    logic                     de;
    logic [R_W-1:0]           red;
    logic [G_W-1:0]           green;
    logic [B_W-1:0]           blue;
    logic                     frame_start;

    modport master (
        output fb_rd_en, fb_addr, hsync, vsync, de, red, green, blue, frame_start,
        input  fb_data, pal_we, pal_idx, pal_rgb, frame_sync_in
    );

    modport slave (
        input  fb_rd_en, fb_addr, hsync, vsync, de, red, green, blue, frame_start,
        output fb_data, pal_we, pal_idx, pal_rgb, frame_sync_in
    );
endinterface

// File: rtl/video_timing_gen.sv
// Display timing generator: h/v counters, linear framebuffer addressing, 16-entry palette, pin-aligned sync/de/RGB.
// Address-to-pin latency RD_LAT+1 clocks, free-running (no backpressure); VTG_GENLOCK_EN adds frame_sync_in genlock.
module video_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int R_W       = 5,
    parameter int G_W       = 5,
    parameter int B_W       = 5,
    parameter int ADDR_W    = 19,
    parameter int RD_LAT    = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    video_timing_gen_if.master bus
);
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW        = $clog2(H_TOTAL);
    localparam int VW        = $clog2(V_TOTAL);
    localparam int RGB_W     = R_W + G_W + B_W;
    localparam int HS_START  = H_ACTIVE + H_FP;
    localparam int HS_END    = HS_START + H_SYNC;
    localparam int VS_START  = V_ACTIVE + V_FP;
    localparam int VS_END    = VS_START + V_SYNC;

    if (longint'(H_ACTIVE) * longint'(V_ACTIVE) > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
        $error("video_timing_gen: H_ACTIVE*V_ACTIVE does not fit in ADDR_W bits");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("video_timing_gen: RD_LAT must be 1..4");
    end

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic org;
    } side_t;

    logic              run;
    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [31:0]       h_ext;
    logic [31:0]       v_ext;
    logic              h_last;
    logic              v_last;
    logic              at_origin;
    logic              active;
    logic              gen_load;
    side_t             cur_side;
    side_t [RD_LAT:0]  dl;
    logic [RGB_W-1:0]  pal [16];
    logic [RGB_W-1:0]  rgb_q;

    assign h_ext     = 32'(h_cnt);
    assign v_ext     = 32'(v_cnt);
    assign h_last    = (h_ext == H_TOTAL - 1);
    assign v_last    = (v_ext == V_TOTAL - 1);
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    assign active    = run && (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);

`ifdef VTG_GENLOCK_EN
    // Sync flops reset high so a request already asserted across reset is not seen as an edge.
    logic [2:0] fs_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) fs_q <= 3'b111;
        else          fs_q <= {fs_q[1:0], bus.frame_sync_in};
    end
    assign gen_load = run && fs_q[1] && !fs_q[2] && !at_origin;
`else
    logic unused_frame_sync;
    assign unused_frame_sync = bus.frame_sync_in;
    assign gen_load          = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run       <= 1'b0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            fb_addr_q <= '0;
        end else if (!run) begin
            run <= 1'b1;
        end else if (gen_load) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            fb_addr_q <= '0;
        end else begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
            if (h_last && v_last)  fb_addr_q <= '0;
            else if (active)       fb_addr_q <= fb_addr_q + ADDR_W'(1);
        end
    end

    assign cur_side.act = active;
    assign cur_side.hs  = (h_ext >= HS_START) && (h_ext < HS_END);
    assign cur_side.vs  = (v_ext >= VS_START) && (v_ext < VS_END);
    assign cur_side.org = run && at_origin;

    // Sideband travels alongside the framebuffer read so it lands on the pins with its pixel.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) dl <= '0;
        else          dl <= {dl[RD_LAT-1:0], cur_side};
    end

    // Lookups read the pre-write contents, so a same-cycle write shows up on the next use.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) pal[i] <= '0;
        end else if (bus.pal_we) begin
            pal[bus.pal_idx] <= bus.pal_rgb;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rgb_q <= '0;
        else          rgb_q <= dl[RD_LAT-1].act ? pal[bus.fb_data] : '0;
    end

    assign bus.fb_rd_en    = active;
    assign bus.fb_addr     = fb_addr_q;
    assign bus.de          = dl[RD_LAT].act;
    assign bus.hsync       = dl[RD_LAT].hs ^ ~HSYNC_POL;
    assign bus.vsync       = dl[RD_LAT].vs ^ ~VSYNC_POL;
    assign bus.frame_start = dl[RD_LAT].org;
    assign bus.red         = rgb_q[RGB_W-1 -: R_W];
    assign bus.green       = rgb_q[B_W +: G_W];
    assign bus.blue        = rgb_q[0 +: B_W];
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on an 8x6 raster: a position-based reference model plus literal frame/sync/palette checks.
module tb_video_timing_gen;
    localparam int HA = 4, HFP = 1, HS = 2, HBP = 1;
    localparam int VA = 3, VFP = 1, VS = 1, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int RD_LAT = 1;
    localparam int L = RD_LAT + 1;
    localparam int ADDR_W = 4;
    localparam int R_W = 5, G_W = 5, B_W = 5;
    localparam int HPOL = 0, VPOL = 0;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    video_timing_gen_if #(.ADDR_W(ADDR_W), .R_W(R_W), .G_W(G_W), .B_W(B_W)) bus ();

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .R_W(R_W), .G_W(G_W), .B_W(B_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc_total = 0;

    // Model: history of {running, raster position} per cycle, index 0 = current cycle.
    int          m_run [8];
    int          m_pos [8];
    logic [14:0] pal_m [16];
    logic [3:0]  mem   [16];
    logic [14:0] exp_rgb;
    logic [3:0]  addr_hist [5];
`ifdef VTG_GENLOCK_EN
    int          fs_lvl [4];
`endif

    int rel = 0;
    bit first_de_seen = 0;
    bit lit_en = 1;
    int last_fs = -1;
    int vs_low = 0, hs_low = 0, de_cnt = 0;
    bit red_chk = 0;
    int de_idx = -1;
    bit hit5_arm = 0, chk_old = 0, chk_new = 0, chk_new_next = 0;
    int gl_chk_at = -1;

    function automatic int act_of(int r, int p);
        return (r != 0 && (p % HT) < HA && (p / HT) < VA) ? 1 : 0;
    endfunction

    function automatic int hs_of(int p);
        return ((p % HT) >= HA + HFP && (p % HT) < HA + HFP + HS) ? 1 : 0;
    endfunction

    function automatic int vs_of(int p);
        return ((p / HT) >= VA + VFP && (p / HT) < VA + VFP + VS) ? 1 : 0;
    endfunction

    // Address is the count of active pixels already passed in the current frame.
    function automatic int addr_of(int p);
        int v, h;
        v = p / HT;
        h = p % HT;
        if (v >= VA) return HA * VA;
        return v * HA + ((h < HA) ? h : HA);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d cycle=%0d", name, got, exp, cyc_total);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            m_run[k] = 0;
            m_pos[k] = 0;
        end
        for (int k = 0; k < 16; k++) pal_m[k] = '0;
        exp_rgb = '0;
`ifdef VTG_GENLOCK_EN
        for (int k = 0; k < 4; k++) fs_lvl[k] = 1;
`endif
        rel = 0;
        first_de_seen = 0;
        last_fs = -1;
        vs_low = 0;
        hs_low = 0;
        de_cnt = 0;
        de_idx = -1;
    endtask

    task automatic tick(input bit rst_lo, input bit we_in, input logic [3:0] idx_in,
                        input logic [14:0] rgb_in, input bit fs);
        logic [3:0]  fbd;
        logic [14:0] rgb;
        logic [3:0]  idx;
        bit          we;
        int          a_look, nrun, npos;
        bit          gl_edge;
        @(negedge clock);
        cyc_total++;
        chk("fb_rd_en", 32'(bus.fb_rd_en), 32'(act_of(m_run[0], m_pos[0])));
        chk("fb_addr", 32'(bus.fb_addr), 32'(addr_of(m_pos[0])));
        chk("de", 32'(bus.de), 32'(act_of(m_run[L], m_pos[L])));
        chk("hsync", 32'(bus.hsync), 32'(hs_of(m_pos[L]) != 0 ? HPOL : 1 - HPOL));
        chk("vsync", 32'(bus.vsync), 32'(vs_of(m_pos[L]) != 0 ? VPOL : 1 - VPOL));
        chk("frame_start", 32'(bus.frame_start), 32'((m_run[L] != 0 && m_pos[L] == 0) ? 1 : 0));
        chk("rgb", 32'({bus.red, bus.green, bus.blue}), 32'(exp_rgb));

        if (bus.de === 1'b1 && !first_de_seen) begin
            chk("first_de_cycle", 32'(rel), 32'(2 + RD_LAT));
            first_de_seen = 1;
        end
        if (chk_old) begin
            chk("pal5_same_cycle_old", 32'(bus.red), 32'd5);
            chk_old = 0;
        end
        if (chk_new_next) begin
            chk("pal5_next_use_new", 32'(bus.red), 32'd31);
            chk_new_next = 0;
            chk_new = 0;
        end
        if (gl_chk_at == cyc_total) begin
`ifdef VTG_GENLOCK_EN
            chk("genlock_addr", 32'(bus.fb_addr), 32'd0);
            chk("genlock_rd_en", 32'(bus.fb_rd_en), 32'd1);
`else
            chk("nogenlock_addr", 32'(bus.fb_addr), 32'd8);
            chk("nogenlock_rd_en", 32'(bus.fb_rd_en), 32'd0);
`endif
        end
        if (bus.frame_start === 1'b1) de_idx = red_chk ? 0 : -1;
        if (red_chk && de_idx >= 0 && bus.de === 1'b1) begin
            chk("red_seq", 32'(bus.red), 32'(de_idx));
            de_idx++;
        end
        if (lit_en) begin
            if (bus.frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    chk("frame_period", 32'(rel - last_fs), 32'd48);
                    chk("vsync_low_per_frame", 32'(vs_low), 32'd8);
                    chk("hsync_low_per_frame", 32'(hs_low), 32'd12);
                    chk("de_per_frame", 32'(de_cnt), 32'd12);
                end
                last_fs = rel;
                vs_low = 0;
                hs_low = 0;
                de_cnt = 0;
            end
            if (last_fs >= 0 && rel == last_fs + 4) chk("hsync_idle_h4", 32'(bus.hsync), 32'd1);
            if (last_fs >= 0 && rel == last_fs + 5) chk("hsync_low_h5", 32'(bus.hsync), 32'd0);
            if (bus.hsync === 1'b0) hs_low++;
            if (bus.vsync === 1'b0) vs_low++;
            if (bus.de === 1'b1) de_cnt++;
        end

        // Framebuffer model answers the address issued RD_LAT cycles ago.
        for (int k = 4; k > 0; k--) addr_hist[k] = addr_hist[k-1];
        addr_hist[0] = bus.fb_addr;
        fbd = mem[addr_hist[RD_LAT]];
        a_look = act_of(m_run[L-1], m_pos[L-1]);
        we = we_in;
        idx = idx_in;
        rgb = rgb_in;
        if (!rst_lo && hit5_arm && a_look != 0 && fbd == 4'd5) begin
            we = 1'b1;
            idx = 4'd5;
            rgb = 15'h7C00;
            hit5_arm = 0;
            chk_old = 1;
            chk_new = 1;
        end else if (!rst_lo && chk_new && !chk_old && a_look != 0 && fbd == 4'd5) begin
            chk_new_next = 1;
        end
        bus.fb_data = fbd;
        bus.pal_we = we && !rst_lo;
        bus.pal_idx = idx;
        bus.pal_rgb = rgb;
        bus.frame_sync_in = fs;

        if (rst_lo) begin
            reset_n = 1'b0;
            model_reset();
        end else begin
            reset_n = 1'b1;
            rel++;
            exp_rgb = (a_look != 0) ? pal_m[mem[4'(addr_of(m_pos[L-1]))]] : 15'd0;
            if (we) pal_m[idx] = rgb;
            gl_edge = 0;
`ifdef VTG_GENLOCK_EN
            for (int k = 3; k > 0; k--) fs_lvl[k] = fs_lvl[k-1];
            fs_lvl[0] = fs ? 1 : 0;
            gl_edge = (fs_lvl[2] == 1 && fs_lvl[3] == 0);
`endif
            if (m_run[0] == 0) begin
                nrun = 1;
                npos = 0;
            end else begin
                nrun = 1;
                npos = (m_pos[0] + 1) % FT;
                if (gl_edge && m_pos[0] != 0) npos = 0;
            end
            for (int k = 7; k > 0; k--) begin
                m_run[k] = m_run[k-1];
                m_pos[k] = m_pos[k-1];
            end
            m_run[0] = nrun;
            m_pos[0] = npos;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'd0, 15'd0, 1'b0);
    endtask

    task automatic reset_literals();
        #1;
        chk("rst_de", 32'(bus.de), 32'd0);
        chk("rst_fb_rd_en", 32'(bus.fb_rd_en), 32'd0);
        chk("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
        chk("rst_hsync", 32'(bus.hsync), 32'(1 - HPOL));
        chk("rst_vsync", 32'(bus.vsync), 32'(1 - VPOL));
        chk("rst_frame_start", 32'(bus.frame_start), 32'd0);
        chk("rst_rgb", 32'({bus.red, bus.green, bus.blue}), 32'd0);
    endtask

    task automatic wait_pos(input int p);
        for (int n = 0; n < 2 * FT && !(m_run[0] != 0 && m_pos[0] == p); n++) idle(1);
    endtask

    initial begin
        bus.fb_data = '0;
        bus.pal_we = 1'b0;
        bus.pal_idx = '0;
        bus.pal_rgb = '0;
        bus.frame_sync_in = 1'b0;
        model_reset();
        for (int k = 0; k < 5; k++) addr_hist[k] = '0;
        for (int i = 0; i < 16; i++) mem[i] = 4'(i);

        repeat (3) tick(1'b1, 1'b0, 4'd0, 15'd0, 1'b0);
        reset_literals();

        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 4'(i), {5'(i), 5'(i), 5'(i)}, 1'b0);
        idle(44);
        red_chk = 1;
        idle(150);
        red_chk = 0;
        hit5_arm = 1;
        idle(100);

        // Reset mid-line 1 for three clocks.
        wait_pos(HT + 2);
        tick(1'b1, 1'b0, 4'd0, 15'd0, 1'b0);
        reset_literals();
        tick(1'b1, 1'b0, 4'd0, 15'd0, 1'b0);
        tick(1'b1, 1'b0, 4'd0, 15'd0, 1'b0);
        idle(110);

`ifdef VTG_GENLOCK_EN
        lit_en = 0;
`endif
        wait_pos(HT + 2);
        tick(1'b0, 1'b0, 4'd0, 15'd0, 1'b1);
        gl_chk_at = cyc_total + 3;
        idle(100);

        lit_en = 0;
        for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
        begin
            int rst_left;
            rst_left = 0;
            for (int c = 0; c < 3000; c++) begin
                bit r, w, f;
                r = 0;
                if (rst_left > 0) begin
                    r = 1;
                    rst_left--;
                end else if ($urandom_range(0, 499) == 0) begin
                    r = 1;
                    rst_left = $urandom_range(0, 2);
                end
                w = ($urandom_range(0, 7) == 0);
                f = ($urandom_range(0, 39) == 0);
                tick(r, w, 4'($urandom), 15'($urandom), f);
            end
        end
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish cycle=%0d", cyc_total);
        $fatal(1, "watchdog");
    end
endmodule
